// File: rtl/radio_const_pkg.sv
// Shared constants and types for the radio datapath filters.
// Holds the interpolator's default taps, default quantisation and FSM state type.
package radio_const_pkg;

  localparam int INTERP_NUM_TAPS   = 32;
  localparam int INTERP_QUANT_BITS = 10;

  // Prototype taps, already scaled by the interpolation factor.
  localparam logic signed [31:0] INTERP_COEFFS [INTERP_NUM_TAPS] = '{default: 32'sd0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } fir_interp_state_e;

endpackage

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample in, INTERPOLATION filtered samples out,
// using a single multiply-accumulate per clock between an upstream and a downstream FIFO.
module fir_interp
  import radio_const_pkg::*;
#(
  parameter int                INTERPOLATION   = 4,
  parameter int                FIFO_DATA_WIDTH = 32,
  parameter int                NUM_TAPS        = INTERP_NUM_TAPS,
  parameter logic signed [31:0] COEFFS [NUM_TAPS] = INTERP_COEFFS,
  parameter int                QUANT_BITS      = INTERP_QUANT_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_fifo_empty,
  output logic                       rd_fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] rd_fifo_data_in,
  input  logic                       wr_fifo_full,
  output logic                       wr_fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] wr_fifo_data_out
);

  localparam int P    = NUM_TAPS / INTERPOLATION;
  localparam int PH_W = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int K_W  = (P > 1) ? $clog2(P) : 1;
  localparam int CI_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int AW   = 64;

  if ((NUM_TAPS % INTERPOLATION) != 0) begin : g_bad_taps
    $error("fir_interp: NUM_TAPS must be a multiple of INTERPOLATION");
  end

  fir_interp_state_e state_r, state_s;

  logic signed [FIFO_DATA_WIDTH-1:0] hist_r [P];
  logic        [PH_W-1:0]            phase_r;
  logic        [K_W-1:0]             k_r;
  logic signed [AW-1:0]              acc_r;
  logic        [FIFO_DATA_WIDTH-1:0] out_reg_r;

  logic        [CI_W-1:0]            coef_idx_s;
  logic signed [AW-1:0]              hist_ext_s;
  logic signed [AW-1:0]              coef_ext_s;
  logic signed [AW-1:0]              prod_s;
  logic signed [AW-1:0]              sum_s;
  logic        [FIFO_DATA_WIDTH-1:0] out_next_s;
  logic                              last_k_s;
  logic                              last_phase_s;
  logic                              rd_req_s;
  logic                              wr_req_s;

  // Polyphase tap select and the single signed multiply-accumulate.
  always_comb begin
    coef_idx_s   = CI_W'(int'(k_r) * INTERPOLATION + int'(phase_r));
    hist_ext_s   = AW'(hist_r[k_r]);
    coef_ext_s   = AW'(COEFFS[coef_idx_s]);
    prod_s       = hist_ext_s * coef_ext_s;
    sum_s        = acc_r + prod_s;
    out_next_s   = FIFO_DATA_WIDTH'(sum_s >>> QUANT_BITS);
    last_k_s     = (k_r == K_W'(P - 1));
    last_phase_s = (phase_r == PH_W'(INTERPOLATION - 1));
  end

  // Next-state logic and FIFO handshake requests.
  always_comb begin
    state_s  = state_r;
    rd_req_s = 1'b0;
    wr_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rd_fifo_empty) begin
          rd_req_s = 1'b1;
          state_s  = MAC;
        end else begin
          state_s  = IDLE;
        end
      end
      MAC: begin
        if (last_k_s) begin
          state_s = WRITE;
        end else begin
          state_s = MAC;
        end
      end
      WRITE: begin
        if (!wr_fifo_full) begin
          wr_req_s = 1'b1;
          state_s  = last_phase_s ? IDLE : MAC;
        end else begin
          state_s  = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Strobes are masked during reset so an aborted operation never pops or pushes.
  assign rd_fifo_rd_en    = rd_req_s & ~rst;
  assign wr_fifo_wr_en    = wr_req_s & ~rst;
  assign wr_fifo_data_out = out_reg_r;

  // State, history, counters and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      phase_r   <= {PH_W{1'b0}};
      k_r       <= {K_W{1'b0}};
      acc_r     <= 64'sd0;
      out_reg_r <= {FIFO_DATA_WIDTH{1'b0}};
      for (int i = 0; i < P; i++) begin
        hist_r[i] <= {FIFO_DATA_WIDTH{1'b0}};
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (!rd_fifo_empty) begin
            hist_r[0] <= rd_fifo_data_in;
            for (int i = P - 1; i > 0; i--) begin
              hist_r[i] <= hist_r[i-1];
            end
            phase_r <= {PH_W{1'b0}};
            k_r     <= {K_W{1'b0}};
            acc_r   <= 64'sd0;
          end
        end
        MAC: begin
          acc_r <= sum_s;
          if (last_k_s) begin
            out_reg_r <= out_next_s;
          end else begin
            k_r <= k_r + K_W'(1'b1);
          end
        end
        WRITE: begin
          if (!wr_fifo_full && !last_phase_s) begin
            phase_r <= phase_r + PH_W'(1'b1);
            k_r     <= {K_W{1'b0}};
            acc_r   <= 64'sd0;
          end
        end
        default: begin
          acc_r <= 64'sd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Scoreboard bench for fir_interp: L=4, 8 taps (1..8), no quantisation, plus a
// second instance with L=1, one tap of 1024 and a 10-bit shift for rounding behaviour.
module tb_fir_interp;

  localparam int DW = 32;
  localparam logic signed [31:0] TB_COEFFS [8] =
    '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
  localparam logic signed [31:0] Q_COEFFS [1] = '{32'sd1024};

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_fifo_empty;
  logic          rd_fifo_rd_en;
  logic [DW-1:0] rd_fifo_data_in;
  logic          wr_fifo_full;
  logic          wr_fifo_wr_en;
  logic [DW-1:0] wr_fifo_data_out;

  logic          q_empty;
  logic          q_rd_en;
  logic [DW-1:0] q_data;
  logic          q_full;
  logic          q_wr_en;
  logic [DW-1:0] q_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic signed [31:0] in_q [$];
  logic signed [31:0] sb   [$];
  int                 rd_cyc [$];
  int                 wr_cyc [$];

  fir_interp #(
    .INTERPOLATION(4), .FIFO_DATA_WIDTH(DW), .NUM_TAPS(8),
    .COEFFS(TB_COEFFS), .QUANT_BITS(0)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_fifo_empty(rd_fifo_empty), .rd_fifo_rd_en(rd_fifo_rd_en), .rd_fifo_data_in(rd_fifo_data_in),
    .wr_fifo_full(wr_fifo_full), .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_data_out(wr_fifo_data_out)
  );

  fir_interp #(
    .INTERPOLATION(1), .FIFO_DATA_WIDTH(DW), .NUM_TAPS(1),
    .COEFFS(Q_COEFFS), .QUANT_BITS(10)
  ) dut_q (
    .clk(clk), .rst(rst),
    .rd_fifo_empty(q_empty), .rd_fifo_rd_en(q_rd_en), .rd_fifo_data_in(q_data),
    .wr_fifo_full(q_full), .wr_fifo_wr_en(q_wr_en), .wr_fifo_data_out(q_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream first-word-fall-through FIFO model.
  initial begin
    rd_fifo_empty   = 1'b1;
    rd_fifo_data_in = '0;
    forever begin
      @(posedge clk);
      if (rd_fifo_rd_en && in_q.size() > 0) void'(in_q.pop_front());
      #1;
      rd_fifo_empty   = (in_q.size() == 0);
      rd_fifo_data_in = (in_q.size() > 0) ? in_q[0] : 32'd0;
    end
  end

  // Output monitor: every push is popped against the scoreboard.
  initial begin
    logic signed [31:0] exp_v;
    forever begin
      @(negedge clk);
      if (rd_fifo_rd_en) rd_cyc.push_back(cyc);
      if (wr_fifo_wr_en) begin
        wr_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %0d, required no write", $signed(wr_fifo_data_out));
        end else begin
          exp_v = sb.pop_front();
          if (wr_fifo_data_out !== exp_v) begin
            errors++;
            $display("FAIL sample: got %0d, required %0d", $signed(wr_fifo_data_out), exp_v);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic do_reset();
    in_q.delete();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_cyc.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_drain(input int limit, output int pending);
    int n = 0;
    while ((sb.size() != 0 || in_q.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    pending = sb.size();
  endtask

  task automatic test_reset();
    in_q.push_back(32'sd5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_fifo_rd_en !== 1'b0 || wr_fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rd_en=%b wr_en=%b, required 0 0", rd_fifo_rd_en, wr_fifo_wr_en);
    end
    checks++;
    if (wr_fifo_data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %0d, required 0", wr_fifo_data_out);
    end
    in_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_fifo_rd_en !== 1'b0 || wr_fifo_wr_en !== 1'b0 || wr_fifo_data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: rd_en=%b wr_en=%b data=%0d, required 0 0 0",
               rd_fifo_rd_en, wr_fifo_wr_en, wr_fifo_data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int e[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
    int pend;
    do_reset();
    foreach (e[i]) sb.push_back(e[i]);
    in_q.push_back(32'sd1); in_q.push_back(32'sd0); in_q.push_back(32'sd0);
    wait_drain(200, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL impulse_drain: %0d outputs pending, required 0", pend);
    end
    checks++;
    if (rd_cyc.size() != 3 || wr_cyc.size() != 12) begin
      errors++;
      $display("FAIL impulse_counts: pops=%0d pushes=%0d, required 3 12", rd_cyc.size(), wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[0] - rd_cyc[0] != 3) begin
        errors++;
        $display("FAIL impulse_latency: got %0d cycles, required 3", wr_cyc[0] - rd_cyc[0]);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL impulse_spacing: got %0d cycles, required 3", wr_cyc[i] - wr_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_step();
    int e[12] = '{2, 4, 6, 8, 12, 16, 20, 24, 12, 16, 20, 24};
    int pend;
    do_reset();
    foreach (e[i]) sb.push_back(e[i]);
    repeat (3) in_q.push_back(32'sd2);
    wait_drain(200, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL step_drain: %0d outputs pending, required 0", pend);
    end
  endtask

  task automatic test_backpressure();
    int e[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
    int pend;
    bit seen = 1'b0;
    do_reset();
    foreach (e[i]) sb.push_back(e[i]);
    in_q.push_back(32'sd1); in_q.push_back(32'sd0); in_q.push_back(32'sd0);
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (wr_fifo_wr_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first_write: no write within 30 cycles, required one");
    end
    @(posedge clk); #1;
    wr_fifo_full = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (wr_fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_wr_en: cycle %0d got %b, required 0", i, wr_fifo_wr_en);
      end
      if (i >= 2) begin
        checks++;
        if (wr_fifo_data_out !== 32'd2) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d got %0d, required 2", i, wr_fifo_data_out);
        end
      end
    end
    @(posedge clk); #1;
    wr_fifo_full = 1'b0;
    wait_drain(200, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d outputs pending, required 0", pend);
    end
  endtask

  task automatic test_starvation();
    int pend;
    bit busy = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) sb.push_back(i);
    in_q.push_back(32'sd1);
    wait_drain(100, pend);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_fifo_rd_en !== 1'b0 || wr_fifo_wr_en !== 1'b0) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL starve_gap: strobe seen during gap, required none");
    end
    @(posedge clk); #1;
    for (int i = 5; i <= 8; i++) sb.push_back(i);
    in_q.push_back(32'sd0);
    wait_drain(100, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL starve_drain: %0d outputs pending, required 0", pend);
    end
  endtask

  task automatic test_reset_mid_mac();
    int pend;
    bit seen = 1'b0;
    bit wrote = 1'b0;
    do_reset();
    sb.push_back(32'sd1);
    in_q.push_back(32'sd1);
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (wr_fifo_wr_en) seen = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_fifo_wr_en !== 1'b0) wrote = 1'b1;
    end
    checks++;
    if (!seen || wrote) begin
      errors++;
      $display("FAIL rst_abort: first_write=%b write_after_reset=%b, required 1 0", seen, wrote);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) sb.push_back(i);
    in_q.push_back(32'sd1); in_q.push_back(32'sd0);
    wait_drain(200, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL rst_drain: %0d outputs pending, required 0", pend);
    end
  endtask

  task automatic test_back_to_back();
    int e[12] = '{3, 6, 9, 12, 10, 8, 6, 4, -18, -16, -14, -12};
    int pend;
    do_reset();
    foreach (e[i]) sb.push_back(e[i]);
    in_q.push_back(32'sd3); in_q.push_back(-32'sd5); in_q.push_back(32'sd7);
    wait_drain(200, pend);
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d outputs pending, required 0", pend);
    end
    checks++;
    if (rd_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_pops: got %0d, required 3", rd_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rd_cyc[i] - rd_cyc[i-1] != 13) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles, required 13", rd_cyc[i] - rd_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_quant();
    logic signed [31:0] v[3] = '{-32'sd1024, -32'sd1, 32'sd3};
    logic signed [31:0] e[3] = '{-32'sd1024, -32'sd1, 32'sd3};
    for (int t = 0; t < 3; t++) begin
      bit got = 1'b0;
      q_data  = v[t];
      q_empty = 1'b0;
      @(posedge clk); #1;
      q_empty = 1'b1;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk);
        if (q_wr_en) got = 1'b1;
      end
      checks++;
      if (!got || q_out !== e[t]) begin
        errors++;
        $display("FAIL quant: input %0d got %0d (write=%b), required %0d", v[t], $signed(q_out), got, e[t]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    wr_fifo_full = 1'b0;
    q_empty      = 1'b1;
    q_data       = '0;
    q_full       = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_impulse();
    test_step();
    test_backpressure();
    test_starvation();
    test_reset_mid_mac();
    test_back_to_back();
    test_quant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
